// File: rtl/ifetch_pkg.sv
// Shared types and defaults for the instruction fetch stage: FSM state, buffered entry, PC step.
package ifetch_pkg;

  localparam int unsigned IFETCH_ADDR_W  = 32;
  localparam int unsigned IFETCH_INSTR_W = 32;
  localparam int unsigned IFETCH_DEPTH   = 2;
  localparam logic [15:0] IFETCH_STEP    = 16'd4;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } ifetch_state_e;

  typedef struct packed {
    logic [IFETCH_ADDR_W-1:0]  addr;
    logic [IFETCH_INSTR_W-1:0] data;
  } ifetch_entry_t;

  function automatic logic word_aligned(input logic [1:0] lsb);
    return lsb == 2'b00;
  endfunction

endpackage

// File: rtl/ifetch_fifo.sv
// Small synchronous FIFO of fetched {addr, data} entries; head holds the last popped
// entry while empty so downstream sees a stable word.
module ifetch_fifo
  import ifetch_pkg::*;
#(
  parameter int unsigned DEPTH   = IFETCH_DEPTH,
  parameter type         entry_t = ifetch_entry_t
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push_i,
  input  entry_t                   push_data_i,
  input  logic                     pop_i,
  output entry_t                   head_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     empty_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  entry_t             mem_q [DEPTH];
  entry_t             last_q;
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               do_pop_c;

  assign empty_o  = (count_q == '0);
  assign do_pop_c = pop_i && !empty_o;

  // Producer is gated on free space upstream, so a push never meets a full FIFO.
  always_comb begin
    count_d = count_q;
    if (push_i && !do_pop_c) begin
      count_d = count_q + CNT_W'(1);
    end else if (!push_i && do_pop_c) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      last_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end
      if (do_pop_c) begin
        last_q   <= mem_q[rd_ptr_q];
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      count_q <= count_d;
    end
  end

  assign head_o  = empty_o ? last_q : mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: single-outstanding req/ack reads at the PC address, buffered for decode.
// Optional alignment fault checking is enabled with IFETCH_ALIGN_CHECK_EN.
module instruction_fetch
  import ifetch_pkg::*;
#(
  parameter int unsigned ADDR_W  = IFETCH_ADDR_W,
  parameter int unsigned INSTR_W = IFETCH_INSTR_W,
  parameter int unsigned DEPTH   = IFETCH_DEPTH,
  parameter logic [15:0] STEP    = IFETCH_STEP
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [ADDR_W-1:0]  pc_address,
  output logic [15:0]        pc_offset,
  output logic               mem_req,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic               mem_ack,
  input  logic [INSTR_W-1:0] mem_rdata,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [INSTR_W-1:0] instr_data,
  output logic [ADDR_W-1:0]  instr_addr
`ifdef IFETCH_ALIGN_CHECK_EN
  ,
  output logic               fetch_fault
`endif
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [ADDR_W-1:0]  addr;
    logic [INSTR_W-1:0] data;
  } entry_t;

  ifetch_state_e      state_q, state_d;
  logic               mem_req_q, mem_req_d;
  logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
  logic               push_c;
  logic               pop_c;
  logic               space_c;
  logic               issue_block_c;
  logic [CNT_W-1:0]   fifo_count;
  logic               fifo_empty;
  entry_t             push_entry;
  entry_t             head_entry;

  assign space_c = (fifo_count < CNT_W'(DEPTH));

`ifdef IFETCH_ALIGN_CHECK_EN
  logic fault_q;
  logic misaligned_c;

  assign misaligned_c  = !word_aligned(pc_address[1:0]);
  assign issue_block_c = fault_q || misaligned_c;

  // Sticky until reset; once set the stage never issues again.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fault_q <= 1'b0;
    end else if (state_q == IDLE && misaligned_c) begin
      fault_q <= 1'b1;
    end
  end

  assign fetch_fault = fault_q;
`else
  assign issue_block_c = 1'b0;
`endif

  // Next state, request register updates, FIFO push and the PC offset.
  always_comb begin
    state_d    = state_q;
    mem_req_d  = mem_req_q;
    mem_addr_d = mem_addr_q;
    push_c     = 1'b0;
    pc_offset  = 16'd0;
    case (state_q)
      IDLE: begin
        if (space_c && !issue_block_c) begin
          state_d    = REQ;
          mem_req_d  = 1'b1;
          mem_addr_d = pc_address;
        end
      end
      REQ: begin
        if (mem_ack) begin
          push_c    = 1'b1;
          pc_offset = STEP;
          state_d   = IDLE;
          mem_req_d = 1'b0;
        end
      end
      default: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
    end
  end

  assign mem_req  = mem_req_q;
  assign mem_addr = mem_addr_q;

  assign push_entry.addr = mem_addr_q;
  assign push_entry.data = mem_rdata;
  assign pop_c           = instr_valid && instr_ready;

  ifetch_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk         (clk),
    .reset_n     (reset_n),
    .push_i      (push_c),
    .push_data_i (push_entry),
    .pop_i       (pop_c),
    .head_o      (head_entry),
    .count_o     (fifo_count),
    .empty_o     (fifo_empty)
  );

  assign instr_valid = !fifo_empty;
  assign instr_data  = head_entry.data;
  assign instr_addr  = head_entry.addr;

endmodule
